// File: rtl/axi4lite_master_bridge.sv
`default_nettype none
// ============================================================================
// Module   : axi4lite_master_bridge
// Summary  : Single-outstanding AXI4-Lite initiator driven by a cmd/rsp handshake.
//            Optional statistics counters: AXI4LITE_MASTER_BRIDGE_STATS_EN.
// Revision : 1.0
// ============================================================================
module axi4lite_master_bridge #(
   parameter int C_M_AXI_DATA_WIDTH = 32,
   parameter int C_M_AXI_ADDR_WIDTH = 11
) (
   input  logic                              M_AXI_ACLK,
   input  logic                              M_AXI_ARESET,
   input  logic                              cmd_valid,
   output logic                              cmd_ready,
   input  logic                              cmd_write,
   input  logic [C_M_AXI_ADDR_WIDTH-1:0]     cmd_addr,
   input  logic [C_M_AXI_DATA_WIDTH-1:0]     cmd_wdata,
   input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,
   output logic                              rsp_valid,
   input  logic                              rsp_ready,
   output logic                              rsp_write,
   output logic [C_M_AXI_DATA_WIDTH-1:0]     rsp_rdata,
   output logic [1:0]                        rsp_resp,
`ifdef AXI4LITE_MASTER_BRIDGE_STATS_EN
   output logic [15:0]                       stat_wr_count,
   output logic [15:0]                       stat_rd_count,
   output logic [15:0]                       stat_err_count,
`endif
   output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
   output logic [2:0]                        M_AXI_AWPROT,
   output logic                              M_AXI_AWVALID,
   input  logic                              M_AXI_AWREADY,
   output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
   output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
   output logic                              M_AXI_WVALID,
   input  logic                              M_AXI_WREADY,
   input  logic [1:0]                        M_AXI_BRESP,
   input  logic                              M_AXI_BVALID,
   output logic                              M_AXI_BREADY,
   output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
   output logic [2:0]                        M_AXI_ARPROT,
   output logic                              M_AXI_ARVALID,
   input  logic                              M_AXI_ARREADY,
   input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
   input  logic [1:0]                        M_AXI_RRESP,
   input  logic                              M_AXI_RVALID,
   output logic                              M_AXI_RREADY
);

   localparam int DW = C_M_AXI_DATA_WIDTH;
   localparam int AW = C_M_AXI_ADDR_WIDTH;
   localparam int SW = C_M_AXI_DATA_WIDTH / 8;

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_WR      = 3'd1;
   localparam logic [2:0] S_WR_RESP = 3'd2;
   localparam logic [2:0] S_RD_ADDR = 3'd3;
   localparam logic [2:0] S_RD_DATA = 3'd4;
   localparam logic [2:0] S_RSP     = 3'd5;

   logic [2:0]    state_q,     state_d;
   logic          cmd_ready_q, cmd_ready_d;
   logic          awvalid_q,   awvalid_d;
   logic          wvalid_q,    wvalid_d;
   logic          bready_q,    bready_d;
   logic          arvalid_q,   arvalid_d;
   logic          rready_q,    rready_d;
   logic [AW-1:0] addr_q,      addr_d;
   logic [DW-1:0] wdata_q,     wdata_d;
   logic [SW-1:0] wstrb_q,     wstrb_d;
   logic          rsp_valid_q, rsp_valid_d;
   logic          rsp_write_q, rsp_write_d;
   logic [DW-1:0] rdata_q,     rdata_d;
   logic [1:0]    resp_q,      resp_d;

   logic          b_fire;
   logic          r_fire;
   logic          aw_done;
   logic          w_done;

   assign b_fire  = bready_q & M_AXI_BVALID;
   assign r_fire  = rready_q & M_AXI_RVALID;
   // A channel is finished once its VALID has dropped or is handshaking now.
   assign aw_done = ~awvalid_q | M_AXI_AWREADY;
   assign w_done  = ~wvalid_q  | M_AXI_WREADY;

   always_comb begin
      state_d     = state_q;
      cmd_ready_d = cmd_ready_q;
      awvalid_d   = awvalid_q;
      wvalid_d    = wvalid_q;
      bready_d    = bready_q;
      arvalid_d   = arvalid_q;
      rready_d    = rready_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      wstrb_d     = wstrb_q;
      rsp_valid_d = rsp_valid_q;
      rsp_write_d = rsp_write_q;
      rdata_d     = rdata_q;
      resp_d      = resp_q;
      case (state_q)
         S_IDLE: begin
            cmd_ready_d = 1'b1;
            if (cmd_valid && cmd_ready_q) begin
               cmd_ready_d = 1'b0;
               addr_d      = cmd_addr;
               wdata_d     = cmd_wdata;
               wstrb_d     = cmd_wstrb;
               rsp_write_d = cmd_write;
               if (cmd_write) begin
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
                  state_d   = S_WR;
               end else begin
                  arvalid_d = 1'b1;
                  state_d   = S_RD_ADDR;
               end
            end
         end
         S_WR: begin
            if (awvalid_q && M_AXI_AWREADY) awvalid_d = 1'b0;
            if (wvalid_q && M_AXI_WREADY)   wvalid_d  = 1'b0;
            if (aw_done && w_done) begin
               bready_d = 1'b1;
               state_d  = S_WR_RESP;
            end
         end
         S_WR_RESP: begin
            if (b_fire) begin
               bready_d    = 1'b0;
               resp_d      = M_AXI_BRESP;
               rdata_d     = '0;
               rsp_valid_d = 1'b1;
               state_d     = S_RSP;
            end
         end
         S_RD_ADDR: begin
            if (M_AXI_ARREADY) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               state_d   = S_RD_DATA;
            end
         end
         S_RD_DATA: begin
            if (r_fire) begin
               rready_d    = 1'b0;
               rdata_d     = M_AXI_RDATA;
               resp_d      = M_AXI_RRESP;
               rsp_valid_d = 1'b1;
               state_d     = S_RSP;
            end
         end
         S_RSP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               cmd_ready_d = 1'b1;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge M_AXI_ACLK) begin
      if (M_AXI_ARESET) begin
         state_q     <= S_IDLE;
         cmd_ready_q <= 1'b0;
         awvalid_q   <= 1'b0;
         wvalid_q    <= 1'b0;
         bready_q    <= 1'b0;
         arvalid_q   <= 1'b0;
         rready_q    <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         wstrb_q     <= '0;
         rsp_valid_q <= 1'b0;
         rsp_write_q <= 1'b0;
         rdata_q     <= '0;
         resp_q      <= 2'b00;
      end else begin
         state_q     <= state_d;
         cmd_ready_q <= cmd_ready_d;
         awvalid_q   <= awvalid_d;
         wvalid_q    <= wvalid_d;
         bready_q    <= bready_d;
         arvalid_q   <= arvalid_d;
         rready_q    <= rready_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         wstrb_q     <= wstrb_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_write_q <= rsp_write_d;
         rdata_q     <= rdata_d;
         resp_q      <= resp_d;
      end
   end

`ifdef AXI4LITE_MASTER_BRIDGE_STATS_EN
   logic [15:0] wr_cnt_q;
   logic [15:0] rd_cnt_q;
   logic [15:0] err_cnt_q;
   logic        err_hit;

   assign err_hit = (b_fire & M_AXI_BRESP[1]) | (r_fire & M_AXI_RRESP[1]);

   always_ff @(posedge M_AXI_ACLK) begin
      if (M_AXI_ARESET) begin
         wr_cnt_q  <= 16'h0000;
         rd_cnt_q  <= 16'h0000;
         err_cnt_q <= 16'h0000;
      end else begin
         if (b_fire && wr_cnt_q != 16'hFFFF)   wr_cnt_q  <= wr_cnt_q + 16'd1;
         if (r_fire && rd_cnt_q != 16'hFFFF)   rd_cnt_q  <= rd_cnt_q + 16'd1;
         if (err_hit && err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
      end
   end

   assign stat_wr_count  = wr_cnt_q;
   assign stat_rd_count  = rd_cnt_q;
   assign stat_err_count = err_cnt_q;
`endif

   assign cmd_ready     = cmd_ready_q;
   assign rsp_valid     = rsp_valid_q;
   assign rsp_write     = rsp_write_q;
   assign rsp_rdata     = rdata_q;
   assign rsp_resp      = resp_q;
   assign M_AXI_AWADDR  = addr_q;
   assign M_AXI_AWPROT  = 3'b000;
   assign M_AXI_AWVALID = awvalid_q;
   assign M_AXI_WDATA   = wdata_q;
   assign M_AXI_WSTRB   = wstrb_q;
   assign M_AXI_WVALID  = wvalid_q;
   assign M_AXI_BREADY  = bready_q;
   assign M_AXI_ARADDR  = addr_q;
   assign M_AXI_ARPROT  = 3'b000;
   assign M_AXI_ARVALID = arvalid_q;
   assign M_AXI_RREADY  = rready_q;

endmodule
`default_nettype wire

// File: tb/tb_axi4lite_master_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi4lite_master_bridge
// Summary  : Directed self-checking bench with a wait-state programmable slave.
// Revision : 1.0
// ============================================================================
module tb_axi4lite_master_bridge;

   localparam int DW = 32;
   localparam int AW = 11;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst       = 1'b1;
   logic          cmd_valid = 1'b0;
   logic          cmd_write = 1'b0;
   logic [AW-1:0] cmd_addr  = '0;
   logic [DW-1:0] cmd_wdata = '0;
   logic [3:0]    cmd_wstrb = '0;
   logic          rsp_ready = 1'b0;
   logic          cmd_ready, rsp_valid, rsp_write;
   logic [DW-1:0] rsp_rdata;
   logic [1:0]    rsp_resp;
`ifdef AXI4LITE_MASTER_BRIDGE_STATS_EN
   logic [15:0]   stat_wr_count, stat_rd_count, stat_err_count;
`endif
   logic [AW-1:0] awaddr, araddr;
   logic [2:0]    awprot, arprot;
   logic          awvalid, wvalid, bready, arvalid, rready;
   logic [DW-1:0] wdata;
   logic [3:0]    wstrb;
   logic          s_awready = 1'b0, s_wready = 1'b0, s_arready = 1'b0;
   logic          s_bvalid  = 1'b0, s_rvalid = 1'b0;
   logic [1:0]    s_bresp   = 2'b00, s_rresp = 2'b00;
   logic [DW-1:0] s_rdata   = '0;

   axi4lite_master_bridge #(.C_M_AXI_DATA_WIDTH(DW), .C_M_AXI_ADDR_WIDTH(AW)) dut (
      .M_AXI_ACLK(clk), .M_AXI_ARESET(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
      .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
`ifdef AXI4LITE_MASTER_BRIDGE_STATS_EN
      .stat_wr_count(stat_wr_count), .stat_rd_count(stat_rd_count),
      .stat_err_count(stat_err_count),
`endif
      .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid),
      .M_AXI_AWREADY(s_awready),
      .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid),
      .M_AXI_WREADY(s_wready),
      .M_AXI_BRESP(s_bresp), .M_AXI_BVALID(s_bvalid), .M_AXI_BREADY(bready),
      .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid),
      .M_AXI_ARREADY(s_arready),
      .M_AXI_RDATA(s_rdata), .M_AXI_RRESP(s_rresp), .M_AXI_RVALID(s_rvalid),
      .M_AXI_RREADY(rready)
   );

   // Slave configuration, written by the stimulus process between commands.
   int         aw_wait = 0, w_wait = 0, ar_wait = 0;
   logic       b_hold  = 1'b0;
   logic [1:0] cfg_bresp = 2'b00, cfg_rresp = 2'b00;
   logic [DW-1:0] cfg_rdata = '0;
   int         b_cnt = 0;

   // Values the DUT presented during the preceding rising edge.
   logic awv_s = 1'b0, wv_s = 1'b0, br_s = 1'b0, arv_s = 1'b0, rr_s = 1'b0;
   logic aw_got = 1'b0, w_got = 1'b0;
   int   aw_cnt = 0, w_cnt = 0, ar_cnt = 0;

   always @(negedge clk) begin
      if (rst) begin
         s_awready = 1'b0; s_wready = 1'b0; s_arready = 1'b0;
         s_bvalid  = 1'b0; s_rvalid = 1'b0;
         aw_got = 1'b0; w_got = 1'b0; aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
      end else begin
         if (awv_s && s_awready) aw_got = 1'b1;
         if (wv_s && s_wready)   w_got  = 1'b1;
         if (s_bvalid && br_s) begin
            s_bvalid = 1'b0; aw_got = 1'b0; w_got = 1'b0; b_cnt++;
         end
         if (aw_got && w_got && !s_bvalid && !b_hold) begin
            s_bvalid = 1'b1; s_bresp = cfg_bresp;
         end
         if (s_rvalid && rr_s) s_rvalid = 1'b0;
         if (arv_s && s_arready) begin
            s_rvalid = 1'b1; s_rdata = cfg_rdata; s_rresp = cfg_rresp;
         end
         if (awvalid) begin s_awready = (aw_cnt >= aw_wait); aw_cnt++; end
         else begin s_awready = 1'b0; aw_cnt = 0; end
         if (wvalid) begin s_wready = (w_cnt >= w_wait); w_cnt++; end
         else begin s_wready = 1'b0; w_cnt = 0; end
         if (arvalid) begin s_arready = (ar_cnt >= ar_wait); ar_cnt++; end
         else begin s_arready = 1'b0; ar_cnt = 0; end
      end
      awv_s = awvalid; wv_s = wvalid; br_s = bready; arv_s = arvalid; rr_s = rready;
   end

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick;
      @(negedge clk);
      cyc++;
   endtask

   task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [3:0] s, output int hs);
      int n = 0;
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
      while (!cmd_ready && n < 20) begin tick; n++; end
      check_eq("cmd_ready", {63'd0, cmd_ready}, 64'd1);
      hs = cyc;
      tick;
      cmd_valid = 1'b0;
   endtask

   task automatic wait_rsp(input int hs, output int lat);
      int n = 0;
      while (!rsp_valid && n < 60) begin tick; n++; end
      check_eq("rsp_arrive", {63'd0, rsp_valid}, 64'd1);
      lat = cyc - hs;
   endtask

   task automatic rsp_accept;
      rsp_ready = 1'b1;
      tick;
      rsp_ready = 1'b0;
      check_eq("rsp_drop", {62'd0, rsp_valid, cmd_ready}, 64'd1);
   endtask

   initial begin
      int hs, lat, n, stable, b0;
      logic [DW-1:0] hold_data;

      repeat (3) tick;
      check_eq("rst_valids", {56'd0, awvalid, wvalid, bready, arvalid, rready, rsp_valid, rsp_write, cmd_ready}, 64'd0);
      check_eq("rst_payload", {rsp_rdata, 30'd0, rsp_resp}, 64'd0);
      check_eq("rst_addr_data", {21'd0, awaddr, wdata}, 64'd0);
      rst = 1'b0;
      tick;
      check_eq("cmd_ready_after_rst", {63'd0, cmd_ready}, 64'd1);

      // zero-wait write
      issue(1'b1, 11'h010, 32'hDEADBEEF, 4'hF, hs);
      check_eq("wr_aw_w_valid", {62'd0, awvalid, wvalid}, 64'd3);
      check_eq("wr_awaddr", {53'd0, awaddr}, 64'h010);
      check_eq("wr_wdata_strb", {28'd0, wdata, wstrb}, 64'hDEADBEEFF);
      check_eq("wr_prot", {58'd0, awprot, arprot}, 64'd0);
      wait_rsp(hs, lat);
      check_eq("wr_latency", lat, 64'd3);
      check_eq("wr_rsp", {29'd0, rsp_write, rsp_resp, rsp_rdata}, {29'd0, 1'b1, 2'b00, 32'd0});
      rsp_accept;

      // read with four ARREADY wait cycles
      ar_wait = 4; cfg_rdata = 32'h12345678; cfg_rresp = 2'b00;
      issue(1'b0, 11'h024, 32'h0, 4'h0, hs);
      n = 0; stable = 0;
      while (arvalid && n < 20) begin
         if (araddr == 11'h024) stable++;
         n++;
         tick;
      end
      check_eq("rd_arvalid_cycles", n, 64'd5);
      check_eq("rd_araddr_stable", stable, 64'd5);
      wait_rsp(hs, lat);
      check_eq("rd_latency", lat, 64'd7);
      check_eq("rd_rsp", {29'd0, rsp_write, rsp_resp, rsp_rdata}, {29'd0, 1'b0, 2'b00, 32'h12345678});
      rsp_accept;
      ar_wait = 0;

      // W handshakes three cycles ahead of AW, then the reverse
      for (int k = 0; k < 2; k++) begin
         aw_wait = (k == 0) ? 3 : 0;
         w_wait  = (k == 0) ? 0 : 3;
         b0 = b_cnt;
         issue(1'b1, 11'h100 + 11'(k), 32'hA000_0000 + k, 4'h3, hs);
         tick;
         check_eq(k == 0 ? "wfirst_valids" : "awfirst_valids", {62'd0, awvalid, wvalid},
                  (k == 0) ? 64'd2 : 64'd1);
         wait_rsp(hs, lat);
         check_eq("split_latency", lat, 64'd6);
         check_eq("split_rsp", {29'd0, rsp_write, rsp_resp, rsp_rdata}, {29'd0, 1'b1, 2'b00, 32'd0});
         rsp_accept;
         tick;
         check_eq("split_one_b", b_cnt - b0, 64'd1);
         check_eq("split_idle", {61'd0, bready, rsp_valid, cmd_ready}, 64'd1);
      end
      aw_wait = 0; w_wait = 0;

      // error responses are forwarded
      cfg_bresp = 2'b10;
      issue(1'b1, 11'h200, 32'h55AA55AA, 4'hF, hs);
      wait_rsp(hs, lat);
      check_eq("slverr_rsp", {29'd0, rsp_write, rsp_resp, rsp_rdata}, {29'd0, 1'b1, 2'b10, 32'd0});
      rsp_accept;
      cfg_bresp = 2'b00;
      cfg_rresp = 2'b11; cfg_rdata = 32'h0BADF00D;
      issue(1'b0, 11'h204, 32'h0, 4'h0, hs);
      wait_rsp(hs, lat);
      check_eq("decerr_rsp", {29'd0, rsp_write, rsp_resp, rsp_rdata}, {29'd0, 1'b0, 2'b11, 32'h0BADF00D});
      rsp_accept;
      cfg_rresp = 2'b00;
`ifdef AXI4LITE_MASTER_BRIDGE_STATS_EN
      check_eq("stat_err", stat_err_count, 64'd2);
`endif

      // response back-pressure with a competing command offered
      cfg_rdata = 32'hA5A5_5A5A;
      issue(1'b0, 11'h300, 32'h0, 4'h0, hs);
      wait_rsp(hs, lat);
      hold_data = rsp_rdata;
      check_eq("hold_first_data", rsp_rdata, 64'hA5A5_5A5A);
      cmd_valid = 1'b1; cmd_write = 1'b1;
      n = 0;
      for (int i = 0; i < 10; i++) begin
         tick;
         if (rsp_valid && rsp_rdata == hold_data && rsp_resp == 2'b00 && !rsp_write &&
             !cmd_ready && !awvalid && !wvalid && !arvalid) n++;
      end
      check_eq("hold_stable_cycles", n, 64'd10);
      cmd_valid = 1'b0;
      rsp_accept;

      // reset while waiting for B
      b_hold = 1'b1;
      issue(1'b1, 11'h040, 32'h11112222, 4'hF, hs);
      n = 0;
      while (!bready && n < 20) begin tick; n++; end
      check_eq("reached_wr_resp", {63'd0, bready}, 64'd1);
      rst = 1'b1;
      tick;
      check_eq("midrst_valids", {58'd0, awvalid, wvalid, bready, arvalid, rready, rsp_valid}, 64'd0);
      check_eq("midrst_cmd_ready", {63'd0, cmd_ready}, 64'd0);
      rst = 1'b0; b_hold = 1'b0;
      tick;
      check_eq("postrst_ready", {62'd0, rsp_valid, cmd_ready}, 64'd1);
      cfg_rdata = 32'hCAFEF00D;
      issue(1'b0, 11'h044, 32'h0, 4'h0, hs);
      wait_rsp(hs, lat);
      check_eq("postrst_rd_latency", lat, 64'd3);
      check_eq("postrst_rd_rsp", {29'd0, rsp_write, rsp_resp, rsp_rdata}, {29'd0, 1'b0, 2'b00, 32'hCAFEF00D});
      rsp_accept;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "simulation time limit reached");
   end

endmodule
`default_nettype wire

// File: doc/axi4lite_master_bridge.md
Name: axi4lite_master_bridge

Overview:
- Single-outstanding AXI4-Lite initiator that turns a simple command/response handshake into AXI4-Lite write and read transactions.
- Lets fabric logic such as sequencers and self-test engines access AXI-mapped register banks (axi4lite_interface_top-based blocks) without a processor.
- One transaction in flight at a time; no bursts, no reordering.

Parameters:
- C_M_AXI_DATA_WIDTH, 32, AXI data width in bits (multiple of 8).
- C_M_AXI_ADDR_WIDTH, 11, AXI byte-address width.

Ports:
- M_AXI_ACLK  in  1  sole clock.
- M_AXI_ARESET  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  bridge accepts command.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  byte address, passed through unmodified.
- cmd_wdata  in  DATA_W  write data.
- cmd_wstrb  in  DATA_W/8  write byte strobes.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_write  out  1  echo of cmd_write.
- rsp_rdata  out  DATA_W  read data; 0 for writes.
- rsp_resp  out  2  BRESP or RRESP as received.
- M_AXI_AWADDR out ADDR_W; M_AXI_AWPROT out 3; M_AXI_AWVALID out 1; M_AXI_AWREADY in 1.
- M_AXI_WDATA out DATA_W; M_AXI_WSTRB out DATA_W/8; M_AXI_WVALID out 1; M_AXI_WREADY in 1.
- M_AXI_BRESP in 2; M_AXI_BVALID in 1; M_AXI_BREADY out 1.
- M_AXI_ARADDR out ADDR_W; M_AXI_ARPROT out 3; M_AXI_ARVALID out 1; M_AXI_ARREADY in 1.
- M_AXI_RDATA in DATA_W; M_AXI_RRESP in 2; M_AXI_RVALID in 1; M_AXI_RREADY out 1.

Behaviour:
- Reset: M_AXI_ARESET is synchronous, active-high. While asserted, and on the first edge after assertion:
  - all VALID/READY outputs are 0, as are rsp_valid, rsp_write, rsp_rdata and rsp_resp;
  - cmd_ready is 0 during reset and 1 in the first cycle after reset deasserts;
  - address and data registers are 0.
- AWPROT and ARPROT are constant 3'b000.
- All AXI and response outputs are registered; no combinational path from any input to any output.
- FSM states: IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, RSP.
- IDLE: cmd_ready = 1. On cmd_valid & cmd_ready, latch addr, wdata, wstrb and write.
  - Write: go to WR; AWVALID and WVALID both assert on the next cycle (latency 1).
  - Read: go to RD_ADDR; ARVALID asserts on the next cycle.
- WR: AW and W channels complete independently.
  - aw_done / w_done flags set on their respective handshake.
  - A VALID deasserts the cycle after its own handshake.
  - AWREADY and WREADY arriving in the same cycle, or in either order, are all legal.
  - Once both handshakes are done, go to WR_RESP with BREADY = 1.
- WR_RESP: on BVALID & BREADY, capture BRESP, deassert BREADY, go to RSP. rsp_rdata = 0, rsp_write = 1.
- RD_ADDR: hold ARVALID and ARADDR stable until ARREADY; then go to RD_DATA with RREADY = 1.
- RD_DATA: on RVALID & RREADY, capture RDATA and RRESP, deassert RREADY, go to RSP. rsp_write = 0.
- RSP: rsp_valid = 1, payload stable until rsp_ready.
  - On handshake, rsp_valid drops next cycle and the state returns to IDLE.
  - cmd_ready is 1 again the cycle after the response handshake, so there is no back-to-back overlap.
- AXI rule: once a VALID is raised, it and its payload stay stable until the matching READY, regardless of cmd_* or rsp_ready activity.
- BREADY and RREADY are never asserted outside their own states. BVALID or RVALID arriving early is ignored until that state is reached.
- SLVERR (2'b10) and DECERR (2'b11) are forwarded on rsp_resp without retry.
- Reset mid-transaction: the FSM returns to IDLE and all valids drop. No response is emitted for the aborted command.
- Minimum latency, cmd handshake to rsp_valid, with zero-wait slave:
  - write: 3 cycles (AW/W, then B, then RSP);
  - read: 3 cycles (AR, then R, then RSP).

Optional Feature:
- Macro: AXI4LITE_MASTER_BRIDGE_STATS_EN.
- When defined, adds three outputs: stat_wr_count[15:0], stat_rd_count[15:0], stat_err_count[15:0].
  - stat_wr_count increments on each B handshake; stat_rd_count on each R handshake.
  - stat_err_count increments when the captured resp[1] = 1.
  - All three saturate at 16'hFFFF and clear on M_AXI_ARESET.
- When not defined, the ports and counters are absent and the remaining behaviour is identical.

Test Plan:
- Write, zero-wait slave: cmd_addr = 11'h010, wdata = 32'hDEADBEEF, wstrb = 4'hF.
  - AWADDR = 0x010 and WDATA = 0xDEADBEEF appear one cycle after the cmd handshake.
  - rsp_valid asserts 3 cycles after the cmd handshake with rsp_resp = 0 and rsp_write = 1.
- Read, RDATA = 32'h12345678 after 4 wait cycles on ARREADY: ARVALID held stable for 5 cycles, then rsp_rdata = 0x12345678 and rsp_resp = 0.
- Write with WREADY 3 cycles before AWREADY, then the reverse ordering: WVALID drops after its own handshake, exactly one B is awaited, and one response is returned per command.
- Slave returns BRESP = 2'b10, then RRESP = 2'b11: rsp_resp = 2 and then 3. With STATS_EN, stat_err_count = 2.
- rsp_ready held low 10 cycles: rsp_valid and its payload stay constant, cmd_ready stays 0, and no AXI VALID is asserted.
- M_AXI_ARESET pulsed while in WR_RESP: all VALID/READY = 0 after the edge, no rsp_valid, cmd_ready = 1 the cycle after release, and the next read completes normally.
